fnd_scan_driver: RTL and testbench

// - Display back end of the FND controller IP. Consumes the four AXI4-Lite slave registers (ctrl, value, dp, bright).
// - Drives a 4-digit common-anode 7-segment display through time-multiplexed scanning with per-digit PWM dimming.
// - Supports hex or decimal rendering. Decimal uses a sequential binary-to-BCD converter.
// - Sits between the AXI slave register file and the board pins.

---
 rtl/fnd_pkg.sv | 19 +
 rtl/fnd_bin2bcd.sv | 84 ++++++++
 rtl/fnd_scan_driver.sv | 132 +++++++++++++
 tb/tb_fnd_scan_driver.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants for the 7-segment scan driver: glyph table, ctrl bit map
// and the binary-to-BCD converter states.
package fnd_pkg;

   localparam int CTRL_EN  = 0;
   localparam int CTRL_DEC = 1;
   localparam int CTRL_LZB = 2;

   // Segment order {g,f,e,d,c,b,a}, active-high
   localparam logic [6:0] SEG_GLYPH [0:15] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

endpackage

// File: rtl/fnd_bin2bcd.sv
// Sequential 16-bit binary to 4-digit BCD converter (double dabble, one bit per cycle).
// state | meaning
// IDLE  | waiting for start; result of the last conversion held on bcd_out/ovf
// SHIFT | 16 add-3/shift iterations, iter_q counts down to terminal count 0
// DONE  | result valid, done pulses for one cycle
module fnd_bin2bcd
   import fnd_pkg::*;
(
   input  logic        ACLK,
   input  logic        ARESETN,
   input  logic        start,
   input  logic [15:0] bin_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] bcd_out,
   output logic        ovf
);

   bcd_state_t  state_q, state_d;
   logic [15:0] bin_q, bin_d;
   logic [15:0] bcd_q, bcd_d;
   logic [3:0]  iter_q, iter_d;
   logic        ovf_q, ovf_d;
   logic [15:0] bcd_adj;

   always_comb begin
      bcd_adj = '0;
      for (int k = 0; k < 4; k++) begin
         bcd_adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3
                                                        : bcd_q[4*k +: 4];
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      iter_d  = iter_q;
      ovf_d   = ovf_q;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               bin_d   = bin_in;
               bcd_d   = '0;
               iter_d  = 4'd15;
               ovf_d   = (bin_in > 16'd9999);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            iter_d = iter_q - 4'd1;
            if (iter_q == 4'd0) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         iter_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         iter_q  <= iter_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign bcd_out = bcd_q;
   assign ovf     = ovf_q;

endmodule

// File: rtl/fnd_scan_driver.sv
// 4-digit 7-segment scan driver: phase/digit scan counters, PWM dimming,
// hex/decimal digit buffer, leading-zero blanking and output polarity.
module fnd_scan_driver
   import fnd_pkg::*;
#(
   parameter int PHASE_DIV  = 6250,
   parameter bit SEG_ACT_LO = 1'b1,
   parameter bit COM_ACT_LO = 1'b1
)(
   input  logic        ACLK,
   input  logic        ARESETN,
   input  logic [31:0] reg_ctrl,
   input  logic [31:0] reg_value,
   input  logic [31:0] reg_dp,
   input  logic [31:0] reg_bright,
   output logic [3:0]  fnd_com,
   output logic [7:0]  fnd_seg,
   output logic        conv_busy
);

   localparam int PCW = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
   localparam logic [PCW-1:0] PHASE_LAST = PCW'(PHASE_DIV - 1);

   logic [PCW-1:0] phase_cnt_q, phase_cnt_d;
   logic [3:0]     phase_q, phase_d;
   logic [1:0]     digit_q, digit_d;
   logic [15:0]    buf_q, buf_d;
   logic           dash_q, dash_d;
   logic [16:0]    seen_q, seen_d;
   logic [3:0]     com_q, com_d;
   logic [7:0]     seg_q, seg_d;

   logic        en, dec_mode, lz_blank;
   logic [15:0] value;
   logic        conv_start, conv_done, conv_ovf;
   logic [15:0] conv_bcd;
   logic [3:0]  nib;
   logic        upper_zero, blanked, dp_bit, lit;
   logic        unused_bits;

   assign en       = reg_ctrl[CTRL_EN];
   assign dec_mode = reg_ctrl[CTRL_DEC];
   assign lz_blank = reg_ctrl[CTRL_LZB];
   assign value    = reg_value[15:0];
   assign unused_bits = ^{reg_ctrl[31:3], reg_value[31:16], reg_dp[31:4], reg_bright[31:4]};

   // A new conversion is only launched from IDLE, so the last value written always wins.
   assign conv_start = !conv_busy && ({value, dec_mode} != seen_q);

   fnd_bin2bcd u_bin2bcd (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .start   (conv_start),
      .bin_in  (value),
      .busy    (conv_busy),
      .done    (conv_done),
      .bcd_out (conv_bcd),
      .ovf     (conv_ovf)
   );

   always_comb begin
      phase_cnt_d = phase_cnt_q + 1'b1;
      phase_d     = phase_q;
      digit_d     = digit_q;
      if (phase_cnt_q == PHASE_LAST) begin
         phase_cnt_d = '0;
         phase_d     = phase_q + 4'd1;
         if (phase_q == 4'd15) digit_d = digit_q + 2'd1;
      end
   end

   always_comb begin
      seen_d = conv_start ? {value, dec_mode} : seen_q;
      buf_d  = buf_q;
      dash_d = dash_q;
      if (!dec_mode) begin
         buf_d  = value;
         dash_d = 1'b0;
      end else if (conv_done) begin
         buf_d  = conv_ovf ? 16'h0000 : conv_bcd;
         dash_d = conv_ovf;
      end
   end

   always_comb begin
      nib = buf_q[4*digit_q +: 4];
      unique case (digit_q)
         2'd3:    upper_zero = (buf_q[15:12] == 4'h0);
         2'd2:    upper_zero = (buf_q[15:8]  == 8'h00);
         2'd1:    upper_zero = (buf_q[15:4]  == 12'h000);
         default: upper_zero = 1'b0;
      endcase
      blanked = lz_blank && !dash_q && upper_zero;
      dp_bit  = reg_dp[digit_q];
      lit     = en && (phase_q <= reg_bright[3:0]) && (phase_q != 4'd15) && (!blanked || dp_bit);
      com_d   = lit ? (4'b0001 << digit_q) : 4'b0000;
      // Segments are frozen for as long as the same digit stays lit.
      if ((com_q != 4'b0000) && (com_d == com_q)) begin
         seg_d = seg_q;
      end else if (!lit) begin
         seg_d = '0;
      end else begin
         seg_d = {dp_bit, blanked ? SEG_BLANK : (dash_q ? SEG_DASH : SEG_GLYPH[nib])};
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         phase_cnt_q <= '0;
         phase_q     <= '0;
         digit_q     <= '0;
         buf_q       <= '0;
         dash_q      <= 1'b0;
         seen_q      <= '0;
         com_q       <= '0;
         seg_q       <= '0;
      end else begin
         phase_cnt_q <= phase_cnt_d;
         phase_q     <= phase_d;
         digit_q     <= digit_d;
         buf_q       <= buf_d;
         dash_q      <= dash_d;
         seen_q      <= seen_d;
         com_q       <= com_d;
         seg_q       <= seg_d;
      end
   end

   assign fnd_com = COM_ACT_LO ? ~com_q : com_q;
   assign fnd_seg = SEG_ACT_LO ? ~seg_q : seg_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed bench for fnd_scan_driver with PHASE_DIV=4 (4 cycles/phase, 64/slot, 256/frame),
// both outputs active-low.
module tb_fnd_scan_driver;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic [31:0] reg_ctrl, reg_value, reg_dp, reg_bright;
   logic [3:0]  fnd_com;
   logic [7:0]  fnd_seg;
   logic        conv_busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc;
   int busy_n;
   logic [3:0] acc;
   logic [6:0] glyph [0:15];

   fnd_scan_driver #(.PHASE_DIV(4), .SEG_ACT_LO(1'b1), .COM_ACT_LO(1'b1)) dut (
      .ACLK       (ACLK),
      .ARESETN    (ARESETN),
      .reg_ctrl   (reg_ctrl),
      .reg_value  (reg_value),
      .reg_dp     (reg_dp),
      .reg_bright (reg_bright),
      .fnd_com    (fnd_com),
      .fnd_seg    (fnd_seg),
      .conv_busy  (conv_busy)
   );

   always #5 ACLK = ~ACLK;

   // Outputs seen after rising edge number cyc reflect scan position t = cyc-1.
   always @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [3:0] com_on(input int d);
      logic [3:0] m;
      m = 4'b0001 << d;
      return ~m;
   endfunction

   function automatic logic [7:0] seg_on(input logic dp, input logic [6:0] g);
      return ~{dp, g};
   endfunction

   // Advance to the second cycle of the given digit/phase.
   task automatic wait_slot(input int d, input int ph);
      int t;
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 600 && !hit; i++) begin
         @(negedge ACLK);
         t = cyc - 1;
         if (t >= 0 && ((t >> 6) & 3) == d && ((t >> 2) & 15) == ph && (t & 3) == 1) hit = 1'b1;
      end
      chk("wait_slot", {31'd0, hit}, 32'd1);
   endtask

   initial begin
      glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      reg_ctrl   = 32'd1;
      reg_value  = 32'h12AF;
      reg_dp     = 32'd0;
      reg_bright = 32'd15;

      repeat (3) @(negedge ACLK);
      chk("rst_com",  fnd_com, 4'hF);
      chk("rst_seg",  fnd_seg, 8'hFF);
      chk("rst_busy", conv_busy, 1'b0);
      ARESETN = 1'b1;

      // hex 0x12AF, full brightness
      wait_slot(3, 0);
      chk("hex_d3_com", fnd_com, com_on(3));
      chk("hex_d3_seg", fnd_seg, seg_on(1'b0, glyph[1]));
      wait_slot(3, 14);
      chk("hex_d3_p14", fnd_com, com_on(3));
      wait_slot(3, 15);
      chk("hex_d3_p15", fnd_com, 4'hF);
      wait_slot(0, 0);
      chk("hex_d0_com", fnd_com, com_on(0));
      chk("hex_d0_seg", fnd_seg, seg_on(1'b0, glyph[15]));
      wait_slot(1, 0);
      chk("hex_d1_seg", fnd_seg, seg_on(1'b0, glyph[10]));
      wait_slot(2, 0);
      chk("hex_d2_com", fnd_com, com_on(2));
      chk("hex_d2_seg", fnd_seg, seg_on(1'b0, glyph[2]));

      // decimal 1234, launched just before digit1's slot opens
      wait_slot(0, 15);
      reg_ctrl  = 32'd3;
      reg_value = 32'd1234;
      @(negedge ACLK);
      chk("dec_busy_rise", conv_busy, 1'b1);
      busy_n = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge ACLK);
         if (conv_busy) busy_n++;
         else break;
      end
      chk("dec_busy_len", busy_n, 17);
      wait_slot(1, 5);
      chk("dec_old_d1", fnd_seg, seg_on(1'b0, glyph[10]));
      wait_slot(3, 0);
      chk("dec_d3", fnd_seg, seg_on(1'b0, glyph[1]));
      wait_slot(0, 0);
      chk("dec_d0", fnd_seg, seg_on(1'b0, glyph[4]));
      wait_slot(1, 0);
      chk("dec_d1", fnd_seg, seg_on(1'b0, glyph[3]));
      wait_slot(2, 0);
      chk("dec_d2", fnd_seg, seg_on(1'b0, glyph[2]));

      // overflow renders dashes
      reg_value = 32'd10000;
      repeat (30) @(negedge ACLK);
      wait_slot(3, 0);
      chk("ovf_d3", fnd_seg, seg_on(1'b0, 7'h40));
      wait_slot(0, 0);
      chk("ovf_d0", fnd_seg, seg_on(1'b0, 7'h40));

      // leading-zero blanking
      reg_ctrl  = 32'd7;
      reg_value = 32'd7;
      repeat (30) @(negedge ACLK);
      wait_slot(0, 0);
      chk("lz7_d0_com", fnd_com, com_on(0));
      chk("lz7_d0_seg", fnd_seg, seg_on(1'b0, glyph[7]));
      wait_slot(1, 0);
      chk("lz7_d1_com", fnd_com, 4'hF);
      wait_slot(3, 0);
      chk("lz7_d3_com", fnd_com, 4'hF);

      reg_value = 32'd0;
      repeat (30) @(negedge ACLK);
      wait_slot(0, 0);
      chk("lz0_d0_com", fnd_com, com_on(0));
      chk("lz0_d0_seg", fnd_seg, seg_on(1'b0, glyph[0]));
      wait_slot(2, 0);
      chk("lz0_d2_com", fnd_com, 4'hF);

      // DP on a blanked leading digit lights it for the DP only
      reg_value = 32'd7;
      reg_dp    = 32'h4;
      repeat (30) @(negedge ACLK);
      wait_slot(2, 0);
      chk("lzdp_d2_com", fnd_com, com_on(2));
      chk("lzdp_d2_seg", fnd_seg, 8'h7F);

      // minimum brightness with DP on digit2
      reg_ctrl   = 32'd3;
      reg_value  = 32'd1234;
      reg_bright = 32'd0;
      repeat (30) @(negedge ACLK);
      wait_slot(2, 0);
      chk("b0_d2_com", fnd_com, com_on(2));
      chk("b0_d2_seg", fnd_seg, seg_on(1'b1, glyph[2]));
      wait_slot(2, 1);
      chk("b0_d2_p1", fnd_com, 4'hF);
      wait_slot(1, 0);
      chk("b0_d1_com", fnd_com, com_on(1));
      chk("b0_d1_seg", fnd_seg, seg_on(1'b0, glyph[3]));

      // value change mid-SHIFT: first conversion completes, second follows
      reg_bright = 32'd15;
      reg_dp     = 32'd0;
      reg_value  = 32'd0;
      repeat (30) @(negedge ACLK);
      reg_value = 32'd1234;
      repeat (5) @(negedge ACLK);
      reg_value = 32'd5678;
      repeat (13) @(negedge ACLK);
      chk("mid_gap_busy", conv_busy, 1'b0);
      @(negedge ACLK);
      chk("mid_restart_busy", conv_busy, 1'b1);
      repeat (30) @(negedge ACLK);
      wait_slot(3, 0);
      chk("mid_d3", fnd_seg, seg_on(1'b0, glyph[5]));
      wait_slot(0, 0);
      chk("mid_d0", fnd_seg, seg_on(1'b0, glyph[8]));

      // asynchronous reset during a conversion
      reg_value = 32'd4321;
      repeat (3) @(negedge ACLK);
      chk("pre_rst_busy", conv_busy, 1'b1);
      #1 ARESETN = 1'b0;
      #1;
      chk("arst_com",  fnd_com, 4'hF);
      chk("arst_seg",  fnd_seg, 8'hFF);
      chk("arst_busy", conv_busy, 1'b0);
      @(negedge ACLK);
      reg_ctrl = 32'd2;
      ARESETN  = 1'b1;

      // disabled: no common lit over a full frame
      acc = 4'hF;
      repeat (260) begin
         @(negedge ACLK);
         acc = acc & fnd_com;
      end
      chk("dis_com", acc, 4'hF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
